ship_rom_arbiter: RTL and testbench

- Shares the single ship sprite ROM between two board renderers: requester A (own board) and requester B (enemy board).
- Each renderer asks for one 32-pixel line of a tile sprite (ship, empty, hit or miss).
- The arbiter picks one requester per cycle using round-robin, drives the ROM address, and returns the ROM line tagged to the requester that asked for it.
- Sits between the board draw modules and the sprite ROM. The ROM has a 7-bit address and a registered 32-bit output with 1-cycle latency.

---
 rtl/ship_rom_arbiter.sv | 85 ++++++++
 tb/tb_ship_rom_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ship_rom_arbiter.sv
// Round-robin arbiter sharing the ship sprite ROM between the own-board (A) and enemy-board (B)
// renderers; tags each returned ROM line with the requester that asked for it.
module ship_rom_arbiter #(
  parameter bit         PRIO_RESET = 1'b0,
  parameter logic [6:0] IDLE_ADDR  = 7'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic [1:0]  type_a,
  input  logic [3:0]  row_a,
  output logic        gnt_a,
  output logic        line_valid_a,
  input  logic        req_b,
  input  logic [1:0]  type_b,
  input  logic [3:0]  row_b,
  output logic        gnt_b,
  output logic        line_valid_b,
  output logic [6:0]  rom_addr,
  input  logic [31:0] rom_data,
  output logic [31:0] line_data
);

  logic       elig_a, elig_b;
  logic       win_a, win_b;
  logic       ptr_q, ptr_d;
  logic [6:0] addr_d;
  logic [6:0] rom_addr_q;
  logic       gnt_a_q, gnt_b_q;
  logic       s1_valid_q, s1_id_q;
  logic       s2_valid_q, s2_id_q;

  // A requester still seeing its own grant is not eligible, preventing a double grant.
  always_comb begin
    elig_a = req_a & ~gnt_a_q;
    elig_b = req_b & ~gnt_b_q;
    win_a  = elig_a & (~elig_b | ~ptr_q);
    win_b  = elig_b & (~elig_a | ptr_q);

    ptr_d = ptr_q;
    if (win_a) begin
      ptr_d = 1'b1;
    end else if (win_b) begin
      ptr_d = 1'b0;
    end

    addr_d = IDLE_ADDR;
    if (win_a) begin
      addr_d = {type_a, 1'b0, row_a};
    end else if (win_b) begin
      addr_d = {type_b, 1'b0, row_b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= PRIO_RESET;
      rom_addr_q <= IDLE_ADDR;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      rom_addr_q <= addr_d;
      gnt_a_q    <= win_a;
      gnt_b_q    <= win_b;
      s1_valid_q <= win_a | win_b;
      s1_id_q    <= win_b;
      // Stage 2 lines up with the ROM's registered output.
      s2_valid_q <= s1_valid_q;
      s2_id_q    <= s1_id_q;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign gnt_a        = gnt_a_q;
  assign gnt_b        = gnt_b_q;
  assign line_valid_a = s2_valid_q & ~s2_id_q;
  assign line_valid_b = s2_valid_q & s2_id_q;
  assign line_data    = rom_data;

endmodule

// File: tb/tb_ship_rom_arbiter.sv
// Bench for ship_rom_arbiter: directed scenarios plus randomized traffic against a
// grant-history reference model and a behavioural 1-cycle-latency sprite ROM.
module tb_ship_rom_arbiter;

  localparam logic [6:0] IdleAddr = 7'h20;

  logic        clk;
  logic        rst_n;
  logic        req_a, req_b;
  logic [1:0]  type_a, type_b;
  logic [3:0]  row_a, row_b;
  logic        gnt_a, gnt_b;
  logic        line_valid_a, line_valid_b;
  logic [6:0]  rom_addr;
  logic [31:0] rom_data;
  logic [31:0] line_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: who was granted at the last edge (0 none, 1 A, 2 B), with its address,
  // who owns the line currently on line_data, and who gets first pick on a tie.
  int         m_ptr;
  int         m_gnt;
  int         m_line;
  logic [6:0] m_addr;
  logic [6:0] m_line_addr;

  ship_rom_arbiter #(
    .PRIO_RESET(1'b0),
    .IDLE_ADDR (IdleAddr)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_a       (req_a),
    .type_a      (type_a),
    .row_a       (row_a),
    .gnt_a       (gnt_a),
    .line_valid_a(line_valid_a),
    .req_b       (req_b),
    .type_b      (type_b),
    .row_b       (row_b),
    .gnt_b       (gnt_b),
    .line_valid_b(line_valid_b),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .line_data   (line_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [6:0] a);
    case (a)
      7'h00:   rom_fn = 32'hFFFF_FFFF;
      7'h41:   rom_fn = 32'h01C0_0380;
      7'h64:   rom_fn = 32'h0F00_00F0;
      7'h2D:   rom_fn = 32'h1111_0000;
      default: rom_fn = {a, ~a, a, ~a, 4'h5};
    endcase
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  task automatic model_reset();
    m_ptr       = 0;
    m_gnt       = 0;
    m_line      = 0;
    m_addr      = IdleAddr;
    m_line_addr = IdleAddr;
  endtask

  task automatic apply_reset();
    req_a = 0; req_b = 0; type_a = 0; type_b = 0; row_a = 0; row_b = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    model_reset();
  endtask

  // Advance one edge; the model decides the winner from the inputs seen at that edge.
  task automatic tick();
    bit ea, eb;
    int w;
    logic [6:0] a;
    ea = req_a && (m_gnt != 1);
    eb = req_b && (m_gnt != 2);
    if (ea && eb) w = (m_ptr == 0) ? 1 : 2;
    else if (ea)  w = 1;
    else if (eb)  w = 2;
    else          w = 0;
    if (w == 1) m_ptr = 1;
    if (w == 2) m_ptr = 0;
    a = (w == 1) ? {type_a, 1'b0, row_a} : (w == 2) ? {type_b, 1'b0, row_b} : IdleAddr;
    @(posedge clk);
    #1;
    m_line      = m_gnt;
    m_line_addr = m_addr;
    m_gnt       = w;
    m_addr      = a;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_checks++;
    if ({gnt_a, gnt_b, line_valid_a, line_valid_b} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: gnt/valid=%b required 0000",
               {gnt_a, gnt_b, line_valid_a, line_valid_b});
    end
    n_checks++;
    if (rom_addr !== IdleAddr) begin
      n_fail++;
      $display("FAIL reset_addr: rom_addr=%h required %h", rom_addr, IdleAddr);
    end
  endtask

  task automatic test_single();
    req_a = 1; type_a = 2'd0; row_a = 4'd0;
    tick();
    n_checks++;
    if (rom_addr !== 7'h00 || gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
      n_fail++;
      $display("FAIL single_grant: addr=%h gnt_a=%b gnt_b=%b required 00 1 0",
               rom_addr, gnt_a, gnt_b);
    end
    req_a = 0;
    tick();
    n_checks++;
    if (line_valid_a !== 1'b1 || line_valid_b !== 1'b0 || line_data !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL single_line: va=%b vb=%b data=%h required 1 0 ffffffff",
               line_valid_a, line_valid_b, line_data);
    end
    n_checks++;
    if (rom_addr !== IdleAddr || gnt_a !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: addr=%h gnt_a=%b required 20 0", rom_addr, gnt_a);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    req_a = 1; type_a = 2'd2; row_a = 4'd1;
    req_b = 1; type_b = 2'd3; row_b = 4'd4;
    tick();
    n_checks++;
    if (gnt_a !== 1'b1 || gnt_b !== 1'b0 || rom_addr !== 7'h41) begin
      n_fail++;
      $display("FAIL simul_first: gnt_a=%b gnt_b=%b addr=%h required 1 0 41",
               gnt_a, gnt_b, rom_addr);
    end
    req_a = 0;
    tick();
    n_checks++;
    if (gnt_b !== 1'b1 || gnt_a !== 1'b0 || rom_addr !== 7'h64) begin
      n_fail++;
      $display("FAIL simul_second: gnt_a=%b gnt_b=%b addr=%h required 0 1 64",
               gnt_a, gnt_b, rom_addr);
    end
    n_checks++;
    if (line_valid_a !== 1'b1 || line_valid_b !== 1'b0 || line_data !== 32'h01C0_0380) begin
      n_fail++;
      $display("FAIL simul_line_a: va=%b vb=%b data=%h required 1 0 01c00380",
               line_valid_a, line_valid_b, line_data);
    end
    req_b = 0;
    tick();
    n_checks++;
    if (line_valid_b !== 1'b1 || line_valid_a !== 1'b0 || line_data !== 32'h0F00_00F0) begin
      n_fail++;
      $display("FAIL simul_line_b: va=%b vb=%b data=%h required 0 1 0f0000f0",
               line_valid_a, line_valid_b, line_data);
    end
    tick();
  endtask

  task automatic test_contention();
    int prev_gnt;
    apply_reset();
    req_a = 1; req_b = 1;
    prev_gnt = 0;
    for (int i = 0; i < 8; i++) begin
      type_a = 2'($urandom); row_a = 4'($urandom);
      type_b = 2'($urandom); row_b = 4'($urandom);
      tick();
      n_checks++;
      // Fixed expectation independent of the model: A on even edges, B on odd.
      if (gnt_a !== (i % 2 == 0) || gnt_b !== (i % 2 == 1)) begin
        n_fail++;
        $display("FAIL contention_gnt[%0d]: gnt_a=%b gnt_b=%b required %b %b",
                 i, gnt_a, gnt_b, (i % 2 == 0), (i % 2 == 1));
      end
      n_checks++;
      if (line_valid_a !== (prev_gnt == 1) || line_valid_b !== (prev_gnt == 2)) begin
        n_fail++;
        $display("FAIL contention_valid[%0d]: va=%b vb=%b required %b %b",
                 i, line_valid_a, line_valid_b, (prev_gnt == 1), (prev_gnt == 2));
      end
      prev_gnt = (i % 2 == 0) ? 1 : 2;
    end
    req_a = 0; req_b = 0;
    tick();
    tick();
  endtask

  task automatic test_a_only();
    int grants;
    logic prev;
    grants = 0;
    prev = gnt_a;
    req_a = 1;
    for (int i = 0; i < 6; i++) begin
      type_a = 2'($urandom); row_a = 4'($urandom);
      tick();
      if (gnt_a === 1'b1) grants++;
      n_checks++;
      if (gnt_a === 1'b1 && prev === 1'b1) begin
        n_fail++;
        $display("FAIL a_only_double[%0d]: gnt_a=%b prev=%b required no back-to-back",
                 i, gnt_a, prev);
      end
      prev = gnt_a;
    end
    n_checks++;
    if (grants != 3) begin
      n_fail++;
      $display("FAIL a_only_count: grants=%0d required 3", grants);
    end
    req_a = 0;
    tick();
    tick();
  endtask

  task automatic test_sweep();
    logic [6:0] exp_a;
    req_b = 1; type_b = 2'd1; row_b = 4'hD;
    tick();
    n_checks++;
    if (rom_addr !== 7'h2D || gnt_b !== 1'b1) begin
      n_fail++;
      $display("FAIL b_addr: addr=%h gnt_b=%b required 2d 1", rom_addr, gnt_b);
    end
    req_b = 0; type_b = 2'd3; row_b = 4'h0;
    tick();
    n_checks++;
    if (line_valid_b !== 1'b1 || line_valid_a !== 1'b0 || line_data !== 32'h1111_0000) begin
      n_fail++;
      $display("FAIL b_line: va=%b vb=%b data=%h required 0 1 11110000",
               line_valid_a, line_valid_b, line_data);
    end
    for (int t = 0; t < 4; t++) begin
      for (int r = 0; r < 16; r++) begin
        req_a = 1; type_a = 2'(t); row_a = 4'(r);
        exp_a = {2'(t), 1'b0, 4'(r)};
        tick();
        req_a = 0;
        n_checks++;
        if (rom_addr !== exp_a || rom_addr[4] !== 1'b0) begin
          n_fail++;
          $display("FAIL sweep_addr[%0d,%0d]: addr=%h required %h", t, r, rom_addr, exp_a);
        end
        tick();
        n_checks++;
        if (line_valid_a !== 1'b1 || line_data !== rom_fn(exp_a)) begin
          n_fail++;
          $display("FAIL sweep_line[%0d,%0d]: va=%b data=%h required 1 %h",
                   t, r, line_valid_a, line_data, rom_fn(exp_a));
        end
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req_a = 1; req_b = 1;
    type_a = 2'd0; row_a = 4'd3; type_b = 2'd2; row_b = 4'd7;
    tick();                      // A wins, B now favoured
    req_a = 0;
    tick();                      // B wins, A favoured
    req_a = 1; req_b = 0;
    tick();                      // A wins, B favoured; gnt_a and line_valid_b high
    n_checks++;
    if (gnt_a !== 1'b1 || line_valid_b !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: gnt_a=%b vb=%b required 1 1", gnt_a, line_valid_b);
    end
    #3 rst_n = 0;
    #1;
    n_checks++;
    if ({gnt_a, gnt_b, line_valid_a, line_valid_b} !== 4'b0000 || rom_addr !== IdleAddr) begin
      n_fail++;
      $display("FAIL async_reset: gnt/valid=%b addr=%h required 0000 20",
               {gnt_a, gnt_b, line_valid_a, line_valid_b}, rom_addr);
    end
    req_a = 0; req_b = 0;
    @(posedge clk);
    #3 rst_n = 1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (line_valid_a !== 1'b0 || line_valid_b !== 1'b0) begin
        n_fail++;
        $display("FAIL stale_valid[%0d]: va=%b vb=%b required 0 0",
                 i, line_valid_a, line_valid_b);
      end
    end
    req_a = 1; req_b = 1;
    tick();
    n_checks++;
    if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_prio: gnt_a=%b gnt_b=%b required 1 0", gnt_a, gnt_b);
    end
    req_a = 0; req_b = 0;
    tick();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      // A request stays up until its grant has been seen.
      if (!req_a || m_gnt == 1) req_a = 1'($urandom_range(0, 1));
      if (!req_b || m_gnt == 2) req_b = 1'($urandom_range(0, 1));
      type_a = 2'($urandom); row_a = 4'($urandom);
      type_b = 2'($urandom); row_b = 4'($urandom);
      tick();
      n_checks++;
      if (gnt_a !== (m_gnt == 1) || gnt_b !== (m_gnt == 2) || rom_addr !== m_addr) begin
        n_fail++;
        $display("FAIL rand_gnt[%0d]: gnt_a=%b gnt_b=%b addr=%h required %b %b %h",
                 i, gnt_a, gnt_b, rom_addr, (m_gnt == 1), (m_gnt == 2), m_addr);
      end
      n_checks++;
      if (line_valid_a !== (m_line == 1) || line_valid_b !== (m_line == 2)) begin
        n_fail++;
        $display("FAIL rand_valid[%0d]: va=%b vb=%b required %b %b",
                 i, line_valid_a, line_valid_b, (m_line == 1), (m_line == 2));
      end
      if (m_line != 0) begin
        n_checks++;
        if (line_data !== rom_fn(m_line_addr)) begin
          n_fail++;
          $display("FAIL rand_data[%0d]: data=%h required %h",
                   i, line_data, rom_fn(m_line_addr));
        end
      end
    end
    req_a = 0; req_b = 0;
    tick();
    tick();
  endtask

  initial begin
    rst_n = 0;
    model_reset();
    test_reset();
    test_single();
    test_simultaneous();
    test_contention();
    test_a_only();
    test_sweep();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
